// File: rtl/tl_pkg.sv
// Shared constants for the transaction-layer FIFO bank controller.
package tl_pkg;
    localparam int NUM_CH = 4;

    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_INIT   = 4'b0010;
    localparam logic [3:0] ST_IDLE   = 4'b0100;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

    localparam int UMBRAL_AF_DEF = 6;
    localparam int UMBRAL_AE_DEF = 0;

    function automatic logic [1:0] oh2idx(input logic [NUM_CH-1:0] oh);
        oh2idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) oh2idx = 2'(i);
        end
    endfunction
endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin grant; the previous cycle's winner is masked so a FIFO
// whose empty flag has not yet caught up with its last pop is never re-popped.
module rr_arbiter4
    import tl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] gnt_o
);
    logic [1:0]        rr_ptr_q;
    logic [1:0]        last_q;
    logic              last_vld_q;
    logic [NUM_CH-1:0] cand;
    logic [1:0]        gidx;
    logic [1:0]        idx;
    logic              found;

    always_comb begin
        cand = req_i;
        if (last_vld_q) cand[last_q] = 1'b0;
        gnt_o = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (en_i && !found && cand[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found) gnt_o[gidx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (found) begin
            rr_ptr_q   <= gidx + 2'd1;
            last_q     <= gidx;
            last_vld_q <= 1'b1;
        end else begin
            last_vld_q <= 1'b0;
        end
    end
endmodule

// File: rtl/tl_fifo_arbiter.sv
// FIFO-bank controller: one-hot state bus, threshold distribution, round-robin
// pops from four input FIFOs and a two-stage route into four destination FIFOs.
module tl_fifo_arbiter
    import tl_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int UMBRAL_W   = 3,
    parameter int CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init,
    input  logic [UMBRAL_W-1:0]          umbral_AF_in,
    input  logic [UMBRAL_W-1:0]          umbral_AE_in,
    input  logic [NUM_CH-1:0]            fifo_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            out_almost_full,
    output logic [3:0]                   state,
    output logic [UMBRAL_W-1:0]          umbral_AF_out,
    output logic [UMBRAL_W-1:0]          umbral_AE_out,
    output logic [NUM_CH-1:0]            pop,
    output logic [NUM_CH-1:0]            push,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic [CNT_W-1:0]             xfer_count,
    output logic                         idle
);
    logic [3:0]            state_q, state_d;
    logic [UMBRAL_W-1:0]   af_q, ae_q;
    logic [NUM_CH-1:0]     pop_q, push_q, push_d, gnt;
    logic [DATA_WIDTH-1:0] data_q, word;
    logic [CNT_W-1:0]      cnt_q;
    logic                  idle_q;
    // [0]: a pop was issued last cycle (word on the bus now); [1]: push visible now
    logic [1:0]            vld_pipe_q;
    logic [1:0]            sel_q;
    logic                  arb_en;

    // Any destination near full blocks all grants: the route is unknown until the word is read.
    assign arb_en = (state_q == ST_ACTIVE) && (out_almost_full == '0);

    rr_arbiter4 u_arb (
        .clk   (clk),
        .reset (reset),
        .en_i  (arb_en),
        .req_i (~fifo_empty),
        .gnt_o (gnt)
    );

    assign word = in_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        push_d = '0;
        if (vld_pipe_q[0]) push_d = NUM_CH'(1) << word[DATA_WIDTH-1 -: 2];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE:   if (fifo_empty != '1) state_d = ST_ACTIVE;
            ST_ACTIVE: if (fifo_empty == '1 && vld_pipe_q == 2'b00) state_d = ST_IDLE;
            default:   state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RESET;
            af_q       <= UMBRAL_W'(UMBRAL_AF_DEF);
            ae_q       <= UMBRAL_W'(UMBRAL_AE_DEF);
            pop_q      <= '0;
            push_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            idle_q     <= 1'b0;
            vld_pipe_q <= '0;
            sel_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT && init) begin
                af_q <= umbral_AF_in;
                ae_q <= umbral_AE_in;
            end
            pop_q      <= gnt;
            vld_pipe_q <= {vld_pipe_q[0], |pop_q};
            sel_q      <= oh2idx(pop_q);
            push_q     <= push_d;
            if (vld_pipe_q[0]) data_q <= word;
            // Counts in step with push so the value includes the word now on data_out.
            cnt_q  <= cnt_q + {{(CNT_W-1){1'b0}}, |push_d};
            idle_q <= (state_d == ST_IDLE);
        end
    end

    assign state         = state_q;
    assign umbral_AF_out = af_q;
    assign umbral_AE_out = ae_q;
    assign pop           = pop_q;
    assign push          = push_q;
    assign data_out      = data_q;
    assign xfer_count    = cnt_q;
    assign idle          = idle_q;
endmodule

// File: tb/tb_tl_fifo_arbiter.sv
// Randomized bench: queue-based input FIFOs plus a transaction-level model of
// scheduling, routing, counting and state, compared every cycle.
module tb_tl_fifo_arbiter;
    localparam int DW = 12;
    localparam int UW = 3;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            reset, init;
    logic [UW-1:0]   af_in, ae_in;
    logic [3:0]      fifo_empty, oaf;
    logic [4*DW-1:0] in_data;
    logic [3:0]      state, pop, push;
    logic [UW-1:0]   af_out, ae_out;
    logic [DW-1:0]   data_out;
    logic [CW-1:0]   xfer_count;
    logic            idle;

    always #5 clk = ~clk;

    logic [DW-1:0] fout [4];
    logic [DW-1:0] fq [4][$];

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign in_data[g*DW +: DW] = fout[g];
    end

    tl_fifo_arbiter #(.DATA_WIDTH(DW), .UMBRAL_W(UW), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .umbral_AF_in    (af_in),
        .umbral_AE_in    (ae_in),
        .fifo_empty      (fifo_empty),
        .in_data         (in_data),
        .out_almost_full (oaf),
        .state           (state),
        .umbral_AF_out   (af_out),
        .umbral_AE_out   (ae_out),
        .pop             (pop),
        .push            (push),
        .data_out        (data_out),
        .xfer_count      (xfer_count),
        .idle            (idle)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state: what the DUT outputs should show this cycle.
    int m_state, m_af, m_ae, m_rr, m_pop, m_push, m_data, m_cnt, m_idle;
    int t = 0;
    int fl_word[$];
    int fl_due[$];

    task automatic tick();
        int n_state, n_pop, n_push, n_data, n_cnt, n_idle, w, c;
        bit drained;
        logic [3:0] pop_seen;
        pop_seen = pop;
        for (int i = 0; i < 4; i++) fifo_empty[i] = (fq[i].size() == 0);
        if (reset) begin
            n_state = 1; m_af = 6; m_ae = 0; n_pop = -1; n_push = 0;
            n_data = 0; n_cnt = 0; m_rr = 0;
            fl_word.delete(); fl_due.delete();
        end else begin
            drained = (fl_word.size() == 0) && (m_push == 0);
            if (m_pop >= 0) begin
                fl_word.push_back(fq[m_pop].size() > 0 ? int'(fq[m_pop][0]) : 0);
                fl_due.push_back(t + 2);
            end
            n_push = 0; n_data = m_data; n_cnt = m_cnt;
            if (fl_word.size() > 0 && fl_due[0] == t + 1) begin
                w = fl_word.pop_front();
                void'(fl_due.pop_front());
                n_push = 1 << (w >> (DW - 2));
                n_data = w;
                n_cnt  = (m_cnt + 1) % 256;
            end
            n_pop = -1;
            if (m_state == 8 && oaf == 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    c = (m_rr + k) % 4;
                    if (n_pop < 0 && !fifo_empty[c] && c != m_pop) n_pop = c;
                end
                if (n_pop >= 0) m_rr = (n_pop + 1) % 4;
            end
            case (m_state)
                1: n_state = 2;
                2: if (init) begin
                       n_state = 2; m_af = int'(af_in); m_ae = int'(ae_in);
                   end else n_state = 4;
                4: n_state = (fifo_empty != 4'hF) ? 8 : 4;
                default: n_state = (fifo_empty == 4'hF && drained) ? 4 : 8;
            endcase
        end
        n_idle = (!reset && n_state == 4) ? 1 : 0;
        @(posedge clk);
        #1;
        t++;
        for (int i = 0; i < 4; i++)
            if (pop_seen[i] === 1'b1 && fq[i].size() > 0) fout[i] = fq[i].pop_front();
        m_state = n_state; m_pop = n_pop; m_push = n_push; m_data = n_data;
        m_cnt = n_cnt; m_idle = n_idle;
        chk("state", int'(state), m_state);
        chk("pop", int'(pop), (m_pop < 0) ? 0 : (1 << m_pop));
        chk("push", int'(push), m_push);
        chk("data_out", int'(data_out), m_data);
        chk("xfer_count", int'(xfer_count), m_cnt);
        chk("idle", int'(idle), m_idle);
        chk("umbral_AF", int'(af_out), m_af);
        chk("umbral_AE", int'(ae_out), m_ae);
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < 4; i++) fq[i].delete();
    endtask

    task automatic do_reset(input int af, input int ae);
        reset = 1'b1; init = 1'b0;
        repeat (3) tick();
        clear_fifos();
        reset = 1'b0; init = 1'b1; af_in = UW'(af); ae_in = UW'(ae);
        repeat (2) tick();
        init = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; af_in = '0; ae_in = '0; oaf = '0; fifo_empty = 4'hF;
        for (int i = 0; i < 4; i++) fout[i] = '0;
        m_state = 1; m_af = 6; m_ae = 0; m_rr = 0; m_pop = -1; m_push = 0;
        m_data = 0; m_cnt = 0; m_idle = 0;

        // Reset, threshold load, single word, full round-robin
        do_reset(5, 1);
        fq[2].push_back(12'hC05);
        repeat (8) tick();
        do_reset(6, 0);
        for (int i = 0; i < 4; i++) begin
            fq[i].push_back(DW'((i << 10) | (16 * i + 1)));
            fq[i].push_back(DW'(((3 - i) << 10) | (16 * i + 2)));
        end
        repeat (14) tick();

        // Backpressure with words in flight
        for (int i = 0; i < 4; i++) fq[i].push_back(DW'(((i + 1) % 4 << 10) | 12'h0A0 | i));
        repeat (3) tick();
        oaf = 4'b0100;
        repeat (5) tick();
        oaf = 4'b0000;
        repeat (10) tick();

        // Single FIFO with three words: alternate-cycle pops
        for (int j = 0; j < 3; j++) fq[1].push_back(DW'((j << 10) | 12'h055));
        repeat (10) tick();

        // Reset mid-transfer; init during ACTIVE is ignored
        for (int i = 0; i < 4; i++) fq[i].push_back(DW'((i << 10) | 12'h3C3));
        repeat (2) tick();
        init = 1'b1;
        repeat (2) tick();
        init = 1'b0;
        do_reset(4, 2);

        // Random traffic long enough to wrap the counter
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++)
                if (fq[i].size() < 8 && $urandom_range(0, 99) < 40)
                    fq[i].push_back(DW'($urandom));
            oaf   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            init  = ($urandom_range(0, 3) == 0);
            af_in = UW'($urandom);
            ae_in = UW'($urandom);
            if (n == 2200) begin
                reset = 1'b1;
                tick();
                clear_fifos();
                reset = 1'b0;
            end else begin
                tick();
            end
        end
        oaf = '0; init = 1'b0;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
